// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and line levels
// used by both the RX and TX sides.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4,
        PARITY    = 3'd5
    } rx_state_t;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the
// idle line level so a reset never looks like a start bit.
module uart_sync
    import uart_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{LINE_IDLE}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 (8E1 when UART_RX_PARITY_EN is defined), MSB first,
// mid-bit sampling of the synchronized line, valid/ready byte output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       busy_o,
    output logic [2:0] dbg_state_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;

    uart_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (rx_i),
        .q_o  (rx_s)
    );

    rx_state_t                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      deliver;
`ifdef UART_RX_PARITY_EN
    logic                      par_q, par_d;
    logic                      parity_err_q, parity_err_d;
`endif

    // Handshake: a byte transfers on any clock where valid_o && ready_i.
    // data_o is held while valid_o && !ready_i; a byte finishing in that
    // window is dropped with overrun_o, while a byte finishing on a transfer
    // cycle replaces the old one directly.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rx_s == LINE_START) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (rx_s == LINE_START) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {shreg_q[UART_DATA_BITS-2:0], rx_s};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s != LINE_STOP) begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                    end else if (par_q != even_parity(shreg_q)) begin
                        parity_err_d = 1'b1;
                        state_d      = IDLE;
`endif
                    end else begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // A stuck-low line must be seen high before another start is armed.
            WAIT_HIGH: begin
                if (rx_s == LINE_IDLE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (deliver) begin
            if (!valid_q || ready_i) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err_o = parity_err_q;
`endif

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule
